elbeth_trap_ctrl: RTL and testbench

- Sequences trap entry and trap return for the ELBETH pipeline.
- Consumes the decode-stage exception and eret indications, plus the external interrupt request.
- Stalls and drains the pipeline, writes mepc/mcause to the CSR file, and redirects fetch to mtvec or mepc with a pipeline flush.
- Sits between the ID stage, the CSR file and the PC-select logic.

---
 rtl/elbeth_trap_ctrl_if.sv | 43 ++++
 rtl/elbeth_trap_ctrl.sv | 127 ++++++++++++
 tb/tb_elbeth_trap_ctrl.sv | 243 ++++++++++++++++++++++++
 3 files changed

// File: rtl/elbeth_trap_ctrl_if.sv
// ELBETH trap controller bundle: decode/CSR/memory status in,
// kill/stall/flush/redirect and CSR write strobes out.
interface elbeth_trap_ctrl_if;
    logic        id_valid;
    logic [31:0] id_pc;
    logic        id_illegal_instruction;
    logic [3:0]  id_except_src;
    logic        id_eret;
    logic        ext_irq;
    logic        csr_mie;
    logic [31:0] csr_mtvec;
    logic [31:0] csr_mepc;
    logic        mem_busy;
    logic        id_kill;
    logic        stall;
    logic        flush;
    logic        pc_redirect;
    logic [31:0] pc_target;
    logic        csr_epc_we;
    logic [31:0] csr_epc_data;
    logic        csr_cause_we;
    logic [31:0] csr_cause_data;
    logic        csr_eret_commit;
    logic        drain_timeout;

    modport master (
        output id_valid, id_pc, id_illegal_instruction,
        output id_except_src, id_eret, ext_irq, csr_mie,
        output csr_mtvec, csr_mepc, mem_busy,
        input  id_kill, stall, flush, pc_redirect, pc_target,
        input  csr_epc_we, csr_epc_data, csr_cause_we,
        input  csr_cause_data, csr_eret_commit, drain_timeout
    );

    modport slave (
        input  id_valid, id_pc, id_illegal_instruction,
        input  id_except_src, id_eret, ext_irq, csr_mie,
        input  csr_mtvec, csr_mepc, mem_busy,
        output id_kill, stall, flush, pc_redirect, pc_target,
        output csr_epc_we, csr_epc_data, csr_cause_we,
        output csr_cause_data, csr_eret_commit, drain_timeout
    );
endinterface

// File: rtl/elbeth_trap_ctrl.sv
// ELBETH trap sequencer: accepts exceptions, interrupts and ERET in ID,
// drains memory, saves mepc/mcause and redirects fetch with a flush.
module elbeth_trap_ctrl #(
    parameter logic [3:0] IRQ_CAUSE   = 4'd11,
    parameter int         DRAIN_LIMIT = 15
) (
    input  logic               clk,
    input  logic               rst,
    elbeth_trap_ctrl_if.slave  bus
);
    localparam int CW = $clog2(DRAIN_LIMIT + 1);

    typedef enum logic [2:0] {
        IDLE,
        DRAIN,
        SAVE,
        REDIRECT,
        RET
    } state_t;

    state_t        state_q, state_d;
    logic [31:0]   pc_q, pc_d;
    logic [31:0]   cause_q, cause_d;
    logic          is_ret_q, is_ret_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          tout_q, tout_d;
    logic          irq_take;

    assign irq_take = bus.ext_irq & bus.csr_mie;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            pc_q     <= '0;
            cause_q  <= '0;
            is_ret_q <= 1'b0;
            cnt_q    <= '0;
            tout_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            cause_q  <= cause_d;
            is_ret_q <= is_ret_d;
            cnt_q    <= cnt_d;
            tout_q   <= tout_d;
        end
    end

    always_comb begin
        state_d             = state_q;
        pc_d                = pc_q;
        cause_d             = cause_q;
        is_ret_d            = is_ret_q;
        cnt_d               = cnt_q;
        tout_d              = tout_q;
        bus.id_kill         = 1'b0;
        bus.stall           = 1'b0;
        bus.flush           = 1'b0;
        bus.pc_redirect     = 1'b0;
        bus.pc_target       = '0;
        bus.csr_epc_we      = 1'b0;
        bus.csr_epc_data    = '0;
        bus.csr_cause_we    = 1'b0;
        bus.csr_cause_data  = '0;
        bus.csr_eret_commit = 1'b0;
        bus.drain_timeout   = tout_q;

        unique case (state_q)
            IDLE: begin
                if (bus.id_valid) begin
                    // Decode exception outranks ERET, which outranks the IRQ.
                    if (bus.id_illegal_instruction) begin
                        pc_d     = bus.id_pc;
                        cause_d  = {28'b0, bus.id_except_src};
                        is_ret_d = 1'b0;
                        state_d  = DRAIN;
                    end else if (bus.id_eret) begin
                        is_ret_d = 1'b1;
                        state_d  = DRAIN;
                    end else if (irq_take) begin
                        pc_d     = bus.id_pc;
                        cause_d  = {1'b1, 27'b0, IRQ_CAUSE};
                        is_ret_d = 1'b0;
                        state_d  = DRAIN;
                    end
                end
                if (state_d == DRAIN) begin
                    bus.id_kill = 1'b1;
                    cnt_d       = '0;
                end
            end
            DRAIN: begin
                bus.stall = 1'b1;
                cnt_d     = cnt_q + CW'(1);
                if (!bus.mem_busy || cnt_q == CW'(DRAIN_LIMIT)) begin
                    if (bus.mem_busy) tout_d = 1'b1;
                    cnt_d   = '0;
                    state_d = is_ret_q ? RET : SAVE;
                end
            end
            SAVE: begin
                bus.stall          = 1'b1;
                bus.csr_epc_we     = 1'b1;
                bus.csr_epc_data   = {pc_q[31:2], 2'b00};
                bus.csr_cause_we   = 1'b1;
                bus.csr_cause_data = cause_q;
                state_d            = REDIRECT;
            end
            REDIRECT: begin
                bus.stall       = 1'b1;
                bus.flush       = 1'b1;
                bus.pc_redirect = 1'b1;
                bus.pc_target   = bus.csr_mtvec;
                state_d         = IDLE;
            end
            RET: begin
                bus.stall           = 1'b1;
                bus.flush           = 1'b1;
                bus.pc_redirect     = 1'b1;
                bus.pc_target       = bus.csr_mepc;
                bus.csr_eret_commit = 1'b1;
                state_d             = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end
endmodule

// File: tb/tb_elbeth_trap_ctrl.sv
// Scoreboard bench for elbeth_trap_ctrl: stimulus queues expected events,
// a negedge monitor pops and compares whenever the DUT shows an event.
module tb_elbeth_trap_ctrl;
    localparam int K_KILL  = 0;
    localparam int K_SAVE  = 1;
    localparam int K_REDIR = 2;
    localparam int K_RET   = 3;

    typedef struct {
        int          kind;
        int          cyc;
        logic [31:0] a;
        logic [31:0] b;
        logic        to;
    } ev_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   n_chk = 0;
    int   n_bad = 0;
    int   stall_cnt = 0;
    logic to_m = 1'b0;
    ev_t  exp_q[$];

    elbeth_trap_ctrl_if bus ();

    elbeth_trap_ctrl dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] req);
        n_chk++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h required 0x%08h (cycle %0d)",
                     nm, act, req, cyc);
        end
    endtask

    function automatic logic [5:0] pat(input int kind);
        case (kind)
            K_KILL:  return 6'b100000;
            K_SAVE:  return 6'b011000;
            K_REDIR: return 6'b000110;
            default: return 6'b000111;
        endcase
    endfunction

    ev_t        e;
    logic [5:0] obs;

    always @(negedge clk) begin
        if (!rst) begin
            if (bus.stall) stall_cnt++;
            obs = {bus.id_kill, bus.csr_epc_we, bus.csr_cause_we,
                   bus.pc_redirect, bus.flush, bus.csr_eret_commit};
            if (obs != 6'b0) begin
                if (exp_q.size() == 0) begin
                    n_chk++;
                    n_bad++;
                    $display("FAIL unexpected_event: got %b required none (cycle %0d)",
                             obs, cyc);
                end else begin
                    e = exp_q.pop_front();
                    chk("event_cycle", cyc, e.cyc);
                    chk("event_kind", {26'b0, obs}, {26'b0, pat(e.kind)});
                    chk("drain_timeout", {31'b0, bus.drain_timeout},
                        {31'b0, e.to});
                    case (e.kind)
                        K_KILL: begin
                            chk("stall_at_kill", {31'b0, bus.stall}, 32'd0);
                            stall_cnt = 0;
                        end
                        K_SAVE: begin
                            chk("epc_data", bus.csr_epc_data, e.a);
                            chk("cause_data", bus.csr_cause_data, e.b);
                        end
                        default: begin
                            chk("pc_target", bus.pc_target, e.a);
                            chk("stall_cycles", stall_cnt, e.b);
                        end
                    endcase
                end
            end
        end
    end

    task automatic garbage();
        bus.id_valid               = 1'($urandom);
        bus.id_pc                  = $urandom;
        bus.id_illegal_instruction = 1'($urandom);
        bus.id_except_src          = 4'($urandom);
        bus.id_eret                = 1'($urandom);
        bus.ext_irq                = 1'($urandom);
        bus.csr_mie                = 1'($urandom);
        bus.csr_mtvec              = $urandom;
        bus.csr_mepc               = $urandom;
    endtask

    task automatic push(input int kind, input int c, input logic [31:0] a,
                        input logic [31:0] b);
        ev_t x;
        x.kind = kind;
        x.cyc  = c;
        x.a    = a;
        x.b    = b;
        x.to   = to_m;
        exp_q.push_back(x);
    endtask

    // One ID-stage offer; b = DRAIN cycles that mem_busy stays high.
    task automatic txn(input logic v, input logic ill, input logic ert,
                       input logic irq, input logic mie,
                       input logic [3:0] src, input logic [31:0] pc,
                       input logic [31:0] mtvec, input logic [31:0] mepc,
                       input int b, input bit rst_in_save);
        int  c;
        int  k;
        bit  acc;
        bit  trap;
        logic [31:0] cause;
        @(posedge clk);
        #1;
        bus.id_valid               = v;
        bus.id_illegal_instruction = ill;
        bus.id_eret                = ert;
        bus.ext_irq                = irq;
        bus.csr_mie                = mie;
        bus.id_except_src          = src;
        bus.id_pc                  = pc;
        bus.csr_mtvec              = $urandom;
        bus.csr_mepc               = $urandom;
        bus.mem_busy               = 1'($urandom);
        c    = cyc;
        acc  = v && (ill || ert || (irq && mie));
        trap = ill || (!ert && irq && mie);
        if (!acc) return;
        cause = ill ? {28'b0, src} : 32'h8000_000B;
        k = (b > 15) ? 15 : b;
        push(K_KILL, c, 32'd0, 32'd0);
        for (int i = 0; i <= k; i++) begin
            @(posedge clk);
            #1;
            garbage();
            bus.mem_busy = (i < b);
        end
        if (b > 15) to_m = 1'b1;
        if (trap) begin
            @(posedge clk);
            #1;
            garbage();
            if (rst_in_save) begin
                rst = 1'b1;
                @(posedge clk);
                #1;
                rst = 1'b0;
                to_m = 1'b0;
                bus.id_valid = 1'b0;
                bus.mem_busy = 1'b0;
                @(negedge clk);
                chk("rst_ctrl_outs",
                    {24'b0, bus.id_kill, bus.stall, bus.flush,
                     bus.pc_redirect, bus.csr_epc_we, bus.csr_cause_we,
                     bus.csr_eret_commit, bus.drain_timeout}, 32'd0);
                chk("rst_pc_target", bus.pc_target, 32'd0);
                chk("rst_epc_data", bus.csr_epc_data, 32'd0);
                chk("rst_cause_data", bus.csr_cause_data, 32'd0);
                return;
            end
            push(K_SAVE, c + 2 + k, {pc[31:2], 2'b00}, cause);
            @(posedge clk);
            #1;
            garbage();
            bus.csr_mtvec = mtvec;
            push(K_REDIR, c + 3 + k, mtvec, k + 3);
        end else begin
            @(posedge clk);
            #1;
            garbage();
            bus.csr_mepc = mepc;
            push(K_RET, c + 2 + k, mepc, k + 2);
        end
        @(posedge clk);
        #1;
        garbage();
        bus.id_valid = 1'b0;
    endtask

    initial begin
        bus.id_valid = 1'b0;
        bus.id_pc = '0;
        bus.id_illegal_instruction = 1'b0;
        bus.id_except_src = '0;
        bus.id_eret = 1'b0;
        bus.ext_irq = 1'b0;
        bus.csr_mie = 1'b0;
        bus.csr_mtvec = '0;
        bus.csr_mepc = '0;
        bus.mem_busy = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk("reset_ctrl_outs",
            {24'b0, bus.id_kill, bus.stall, bus.flush, bus.pc_redirect,
             bus.csr_epc_we, bus.csr_cause_we, bus.csr_eret_commit,
             bus.drain_timeout}, 32'd0);
        chk("reset_pc_target", bus.pc_target, 32'd0);

        txn(1, 1, 0, 0, 0, 4'd2, 32'h100, 32'h200, 32'h0, 0, 0);
        txn(1, 0, 1, 0, 0, 4'd0, 32'h0, 32'h0, 32'h104, 0, 0);
        txn(1, 1, 0, 1, 1, 4'd2, 32'h140, 32'h300, 32'h0, 0, 0);
        txn(1, 0, 0, 1, 1, 4'd7, 32'h80, 32'h400, 32'h0, 1, 0);
        txn(1, 0, 0, 1, 0, 4'd0, 32'h88, 32'h0, 32'h0, 0, 0);
        txn(1, 1, 0, 0, 0, 4'd5, 32'h203, 32'h500, 32'h0, 3, 0);
        txn(0, 1, 0, 0, 0, 4'd3, 32'h90, 32'h0, 32'h0, 0, 0);
        txn(1, 1, 0, 0, 0, 4'd4, 32'ha0, 32'h600, 32'h0, 30, 0);
        txn(1, 0, 1, 0, 0, 4'd0, 32'h0, 32'h0, 32'h208, 2, 0);
        txn(1, 1, 0, 0, 0, 4'd6, 32'hb0, 32'h700, 32'h0, 0, 1);

        for (int n = 0; n < 300; n++) begin
            int b;
            b = ($urandom % 8 == 0) ? int'($urandom_range(12, 20))
                                    : int'($urandom_range(0, 4));
            txn(1'($urandom % 4 != 0), 1'($urandom % 3 == 0),
                1'($urandom % 3 == 0), 1'($urandom),
                1'($urandom), 4'($urandom), $urandom, $urandom,
                $urandom, b, ($urandom % 25 == 0));
        end

        repeat (5) @(posedge clk);
        chk("queue_drained", exp_q.size(), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_bad);
        $finish;
    end
endmodule
